// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/compare ops, iterative 1-bit/cycle shifter, valid/ready both sides.
// Optional macro FAST_SHIFT_EN: shifts use a single-cycle barrel shifter; the SHIFT state and counter are not built.
module alu_exec_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5,
    parameter int unsigned TAG_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctl,
    input  logic [XLEN-1:0]    op_a,
    input  logic [XLEN-1:0]    op_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    result,
    output logic               zero,
    output logic [TAG_W-1:0]   out_tag,
    output logic               illegal
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic                accept;
    logic [SHAMT_W-1:0]  shamt;
    logic [XLEN-1:0]     comb_res;
    logic [XLEN-1:0]     sll_res;
    logic [XLEN-1:0]     srl_res;
    logic [XLEN-1:0]     sra_res;
    logic                comb_illegal;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign shamt    = op_b[SHAMT_W-1:0];

`ifdef FAST_SHIFT_EN
    assign sll_res = op_a << shamt;
    assign srl_res = op_a >> shamt;
    assign sra_res = XLEN'($signed(op_a) >>> shamt);
`else
    // The single-cycle path only ever sees shifts with shamt==0, which pass op_a through.
    assign sll_res = op_a;
    assign srl_res = op_a;
    assign sra_res = op_a;

    logic [XLEN-1:0]     work;
    logic [XLEN-1:0]     shift_next;
    logic [SHAMT_W-1:0]  cnt;
    logic [3:0]          shift_op;
    logic                start_shift;

    assign start_shift = ((alu_ctl == OP_SLL) || (alu_ctl == OP_SRL) || (alu_ctl == OP_SRA))
                         && (shamt != '0);

    // One-bit step of the iterative shifter.
    always_comb begin
        case (shift_op)
            OP_SLL:  shift_next = {work[XLEN-2:0], 1'b0};
            OP_SRL:  shift_next = {1'b0, work[XLEN-1:1]};
            default: shift_next = {work[XLEN-1], work[XLEN-1:1]};
        endcase
    end
`endif

    // Single-cycle result; undefined codes yield zero with the illegal flag.
    always_comb begin
        comb_res     = '0;
        comb_illegal = 1'b0;
        case (alu_ctl)
            OP_AND:  comb_res = op_a & op_b;
            OP_OR:   comb_res = op_a | op_b;
            OP_ADD:  comb_res = op_a + op_b;
            OP_XOR:  comb_res = op_a ^ op_b;
            OP_SUB:  comb_res = op_a - op_b;
            OP_SLL:  comb_res = sll_res;
            OP_SRL:  comb_res = srl_res;
            OP_SRA:  comb_res = sra_res;
            OP_SLTU: comb_res = XLEN'(op_a < op_b);
            OP_SLT:  comb_res = XLEN'($signed(op_a) < $signed(op_b));
            default: comb_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            out_tag   <= '0;
            illegal   <= 1'b0;
`ifndef FAST_SHIFT_EN
            work      <= '0;
            cnt       <= '0;
            shift_op  <= OP_AND;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        out_tag <= in_tag;
                        illegal <= comb_illegal;
`ifndef FAST_SHIFT_EN
                        if (start_shift) begin
                            work      <= op_a;
                            cnt       <= shamt;
                            shift_op  <= alu_ctl;
                            state     <= SHIFT;
                            out_valid <= 1'b0;
                        end else
`endif
                        begin
                            result    <= comb_res;
                            zero      <= (comb_res == '0);
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifndef FAST_SHIFT_EN
                SHIFT: begin
                    // Last step lands directly in the result register.
                    if (cnt == SHAMT_W'(1)) begin
                        result    <= shift_next;
                        zero      <= (shift_next == '0);
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        work <= shift_next;
                    end
                    cnt <= cnt - SHAMT_W'(1);
                end
`endif
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: transaction-level model checked every cycle plus literal pins.
module tb_alu_exec_unit;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  out_tag;
    logic        illegal;

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctl(alu_ctl), .op_a(op_a), .op_b(op_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .out_tag(out_tag), .illegal(illegal)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [4:0]  tag;
        logic        ill;
        int          acc;
        int          due;
        int          done;
    } txn_t;

    txn_t q[$];
    txn_t lg[$];
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    bit   mon_en = 0;
    bit   head_ready;
    bit   model_ready;
    txn_t nt;
    int   nlat;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Architectural meaning of each code, plus the cycle count the op should take.
    function automatic void model(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        r   = 32'd0;
        ill = 1'b0;
        lat = 1;
        case (ctl)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0011: r = a ^ b;
            4'b0110: r = a - b;
            4'b0100: begin r = a << sh; lat = sh + 1; end
            4'b0101: begin r = a >> sh; lat = sh + 1; end
            4'b1001: begin r = $signed(a) >>> sh; lat = sh + 1; end
            4'b0111: r = (a < b) ? 32'd1 : 32'd0;
            4'b1000: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ill = 1'b1;
        endcase
`ifdef FAST_SHIFT_EN
        lat = 1;
`endif
    endfunction

    // Compare process: at most one op in flight, visible from its due cycle until taken.
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                q.delete();
            end else begin
                head_ready  = (q.size() > 0) && (cyc >= q[0].due);
                model_ready = (q.size() == 0) || (head_ready && out_ready);
                chk("in_ready", in_ready, model_ready);
                if (!head_ready) begin
                    chk("out_valid_low", out_valid, 0);
                end else begin
                    chk("out_valid", out_valid, 1);
                    chk("result", result, q[0].res);
                    chk("zero", zero, q[0].zero);
                    chk("out_tag", out_tag, q[0].tag);
                    chk("illegal", illegal, q[0].ill);
                    if (out_ready) begin
                        q[0].done = cyc;
                        lg.push_back(q[0]);
                        void'(q.pop_front());
                    end
                end
                if (in_valid && model_ready) begin
                    model(alu_ctl, op_a, op_b, nt.res, nt.ill, nlat);
                    nt.zero = (nt.res == 32'd0);
                    nt.tag  = in_tag;
                    nt.acc  = cyc;
                    nt.due  = cyc + nlat;
                    nt.done = -1;
                    q.push_back(nt);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge with operands scrambled.
    task automatic issue(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        int n;
        n        = 0;
        in_valid = 1'b1;
        alu_ctl  = ctl;
        op_a     = a;
        op_b     = b;
        in_tag   = tag;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) chk("issue_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_ctl  = 4'b1111;
        op_a     = ~a;
        op_b     = ~b;
        in_tag   = ~tag;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctl   = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        in_tag    = 5'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_zero", zero, 1);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_illegal", illegal, 0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mon_en    = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        issue(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd1);
        issue(4'b0110, 32'd5, 32'd5, 5'd2);
        issue(4'b1001, 32'h8000_0000, 32'd4, 5'd3);
        issue(4'b1000, 32'hFFFF_FFFF, 32'd1, 5'd4);
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd5);
        issue(4'b0100, 32'd1, 32'd0, 5'd7);
        issue(4'b0101, 32'h8000_0000, 32'd31, 5'd8);
        issue(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd9);
        issue(4'b0100, 32'd3, 32'h0000_0021, 5'd10);

        issue(4'b0011, 32'h0000_F0F0, 32'h0000_0FF0, 5'd6);
        out_ready = 1'b0;
        fork
            issue(4'b0001, 32'd3, 32'd4, 5'd11);
            begin
                repeat (3) begin
                    @(negedge clk);
                    chk("xor_hold_result", result, 32'h0000_FF00);
                    chk("xor_hold_tag", out_tag, 5'd6);
                    chk("xor_hold_in_ready", in_ready, 0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join

        issue(4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12);
        issue(4'b0000, 32'h0000_00FF, 32'h0000_000F, 5'd13);

        issue(4'b0100, 32'd1, 32'd20, 5'd14);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_zero", zero, 1);
        chk("midrst_illegal", illegal, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        issue(4'b0010, 32'd2, 32'd3, 5'd15);
        drain();

        chk("log_count", lg.size(), 14);
        if (lg.size() >= 14) begin
            chk("lit_add_res", lg[0].res, 32'h8000_0000);
            chk("lit_add_zero", lg[0].zero, 0);
            chk("lit_sub_res", lg[1].res, 32'd0);
            chk("lit_sub_zero", lg[1].zero, 1);
            chk("lit_b2b", lg[1].due - lg[0].due, 1);
            chk("lit_sra_res", lg[2].res, 32'hF800_0000);
`ifdef FAST_SHIFT_EN
            chk("lit_sra_lat", lg[2].due - lg[2].acc, 1);
`else
            chk("lit_sra_lat", lg[2].due - lg[2].acc, 5);
`endif
            chk("lit_slt", lg[3].res, 32'd1);
            chk("lit_sltu", lg[4].res, 32'd0);
            chk("lit_sltu_zero", lg[4].zero, 1);
            chk("lit_sll0_res", lg[5].res, 32'd1);
            chk("lit_sll0_lat", lg[5].due - lg[5].acc, 1);
            chk("lit_srl31", lg[6].res, 32'd1);
            chk("lit_add_wrap", lg[7].res, 32'd0);
            chk("lit_sll_shamt_mask", lg[8].res, 32'd6);
            chk("lit_xor", lg[9].res, 32'h0000_FF00);
            chk("lit_or", lg[10].res, 32'd7);
            chk("lit_same_edge", lg[10].acc - lg[9].done, 0);
            chk("lit_illegal", lg[11].ill, 1);
            chk("lit_illegal_res", lg[11].res, 32'd0);
            chk("lit_and", lg[12].res, 32'h0000_000F);
            chk("lit_and_ill", lg[12].ill, 0);
            chk("lit_post_rst_add", lg[13].res, 32'd5);
            chk("lit_post_rst_tag", lg[13].tag, 5'd15);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
